// File: rtl/cpu_types_pkg.sv
// Shared CPU encodings: MDU operation codes and MDU sequencer states.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      MUL  = 2'd0,
      MULU = 2'd1,
      DIV  = 2'd2,
      DIVU = 2'd3
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } mdu_state_t;

endpackage

// File: rtl/exe_mdu.sv
// Iterative radix-2 multiply/divide unit: one bit per cycle on operand magnitudes, sign fix-up at the end.
// done_out pulses WIDTH+1 edges after start is sampled; stall_out holds the pipeline while busy or on a fresh start.
module exe_mdu
   import cpu_types_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start_in,
   input  logic [1:0]       op_in,
   input  logic [WIDTH-1:0] opa_in,
   input  logic [WIDTH-1:0] opb_in,
   input  logic             flush_in,
   output logic             busy_out,
   output logic             stall_out,
   output logic             done_out,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             divzero_out
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   mdu_state_t       state_q, state_d;
   mdu_op_t          op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             neg_q, neg_d;
   logic             sa_q, sa_d;
   logic             dz_q, dz_d;
   logic             done_q, done_d;

   mdu_op_t            op_in_e;
   logic               is_sgn, sa_in, sb_in, op_q_div, rem_ge;
   logic [WIDTH-1:0]   a_mag, b_mag, rem_sub, rem_fix, quo_fix;
   logic [WIDTH:0]     mul_sum, rem_sh;
   logic [2*WIDTH-1:0] prod;

   assign op_in_e  = mdu_op_t'(op_in);
   assign is_sgn   = (op_in_e == MUL) || (op_in_e == DIV);
   assign sa_in    = is_sgn & opa_in[WIDTH-1];
   assign sb_in    = is_sgn & opb_in[WIDTH-1];
   assign a_mag    = sa_in ? -opa_in : opa_in;
   assign b_mag    = sb_in ? -opb_in : opb_in;
   assign op_q_div = (op_q == DIV) || (op_q == DIVU);

   // Multiply: {acc_hi, acc_lo} holds partial product over the remaining multiplier bits.
   assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
   // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
   assign rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign rem_ge   = rem_sh >= {1'b0, b_q};
   assign rem_sub  = rem_sh[WIDTH-1:0] - b_q;

   assign prod     = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
   assign rem_fix  = sa_q ? -acc_hi_q : acc_hi_q;
   assign quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      b_d      = b_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      dz_d     = dz_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start_in) begin
               state_d  = CALC;
               op_d     = op_in_e;
               cnt_d    = '0;
               sa_d     = sa_in;
               neg_d    = sa_in ^ sb_in;
               acc_hi_d = '0;
               if ((op_in_e == DIV) || (op_in_e == DIVU)) begin
                  acc_lo_d = a_mag;
                  b_d      = b_mag;
               end else begin
                  acc_lo_d = b_mag;
                  b_d      = a_mag;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (op_q_div) begin
               acc_hi_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
            end else begin
               acc_hi_d = mul_sum[WIDTH:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = SIGN;
            end
         end
         SIGN: begin
            state_d = DONE;
            done_d  = 1'b1;
            if (op_q_div) begin
               // A zero divisor leaves the dividend magnitude in acc_hi, so rem_fix restores the dividend.
               hi_d = rem_fix;
               lo_d = (b_q == '0) ? '1 : quo_fix;
               dz_d = (b_q == '0);
            end else begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush_in) begin
         state_d = IDLE;
         done_d  = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
         dz_d    = dz_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         op_q     <= MUL;
         cnt_q    <= '0;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         dz_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         b_q      <= b_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         dz_q     <= dz_d;
         done_q   <= done_d;
      end
   end

   assign busy_out    = (state_q == CALC) || (state_q == SIGN);
   assign stall_out   = busy_out | (start_in & ~flush_in & ((state_q == IDLE) || (state_q == DONE)));
   assign done_out    = done_q;
   assign hi_out      = hi_q;
   assign lo_out      = lo_q;
   assign divzero_out = dz_q;

endmodule

// File: tb/tb_exe_mdu.sv
// Directed bench for exe_mdu (WIDTH=32): results, latency, divide-by-zero, flush, back-to-back and reset.
module tb_exe_mdu;
   import cpu_types_pkg::*;

   logic        CLK;
   logic        RST;
   logic        start_in;
   logic [1:0]  op_in;
   logic [31:0] opa_in;
   logic [31:0] opb_in;
   logic        flush_in;
   logic        busy_out;
   logic        stall_out;
   logic        done_out;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        divzero_out;

   int n_checks;
   int n_fail;

   exe_mdu #(.WIDTH(32)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .start_in    (start_in),
      .op_in       (op_in),
      .opa_in      (opa_in),
      .opb_in      (opb_in),
      .flush_in    (flush_in),
      .busy_out    (busy_out),
      .stall_out   (stall_out),
      .done_out    (done_out),
      .hi_out      (hi_out),
      .lo_out      (lo_out),
      .divzero_out (divzero_out)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge with the DUT in IDLE or DONE. Returns edges from the
   // sampling edge to done_out (or 60 on timeout) and the number of busy cycles seen.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input int flush_at,
                        output int lat, output int busy_cnt, output bit seen_done);
      start_in = 1'b1;
      op_in    = op;
      opa_in   = a;
      opb_in   = b;
      #1;
      chk("stall_on_start", stall_out, 1);
      @(posedge CLK);
      #1;
      start_in  = 1'b0;
      lat       = 0;
      busy_cnt  = 0;
      seen_done = 1'b0;
      while (lat < 60) begin
         if (done_out) begin
            seen_done = 1'b1;
            break;
         end
         if (busy_out) busy_cnt++;
         start_in = (lat == poke_at);
         if (lat == poke_at) begin
            op_in  = MULU;
            opa_in = 32'd2;
            opb_in = 32'd2;
         end
         flush_in = (lat == flush_at);
         @(posedge CLK);
         #1;
         lat++;
      end
      start_in = 1'b0;
      flush_in = 1'b0;
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int  lat;
      int  bc;
      bit  sd;
      do_op(op, a, b, -1, -1, lat, bc, sd);
      chk({tag, "_done"}, sd, 1);
      chk({tag, "_lat"}, lat, 33);
      chk({tag, "_busy"}, bc, 33);
      chk({tag, "_hi"}, hi_out, exp_hi);
      chk({tag, "_lo"}, lo_out, exp_lo);
   endtask

   initial begin
      int lat;
      int bc;
      int dcnt;
      bit sd;
      n_checks = 0;
      n_fail   = 0;
      RST      = 1'b1;
      start_in = 1'b0;
      op_in    = 2'd0;
      opa_in   = '0;
      opb_in   = '0;
      flush_in = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_busy", busy_out, 0);
      chk("rst_stall", stall_out, 0);
      chk("rst_done", done_out, 0);
      chk("rst_hi", hi_out, 0);
      chk("rst_lo", lo_out, 0);
      chk("rst_dz", divzero_out, 0);
      RST = 1'b0;
      @(posedge CLK);
      #1;

      run("mulu_max", MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      @(posedge CLK);
      #1;
      chk("done_one_cycle", done_out, 0);
      chk("hold_hi", hi_out, 32'hFFFFFFFE);
      chk("hold_lo", lo_out, 32'h00000001);

      run("mul_neg", MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);

      run("divu_zero", DIVU, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
      chk("divu_zero_dz", divzero_out, 1);
      run("mulu_keep_dz", MULU, 32'd3, 32'd4, 32'd0, 32'd12);
      chk("mul_keeps_dz", divzero_out, 1);
      run("divu_9_4", DIVU, 32'd9, 32'd4, 32'd1, 32'd2);
      chk("divu_clr_dz", divzero_out, 0);
      // Issued from the DONE cycle of the previous operation.
      run("b2b_mulu", MULU, 32'd6, 32'd7, 32'd0, 32'd42);

      run("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
      chk("div_min_m1_dz", divzero_out, 0);
      run("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);

      do_op(DIVU, 32'd100, 32'd7, 5, -1, lat, bc, sd);
      chk("ignore_start_lat", lat, 33);
      chk("ignore_start_hi", hi_out, 32'd2);
      chk("ignore_start_lo", lo_out, 32'd14);

      do_op(DIVU, 32'd1000, 32'd3, -1, 9, lat, bc, sd);
      chk("flush_no_done", sd, 0);
      chk("flush_busy_cycles", bc, 10);
      chk("flush_hi", hi_out, 32'd2);
      chk("flush_lo", lo_out, 32'd14);

      start_in = 1'b1;
      flush_in = 1'b1;
      op_in    = DIVU;
      opa_in   = 32'd8;
      opb_in   = 32'd2;
      #1;
      chk("start_flush_stall", stall_out, 0);
      @(posedge CLK);
      #1;
      start_in = 1'b0;
      flush_in = 1'b0;
      chk("start_flush_busy", busy_out, 0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK);
         #1;
         if (done_out || busy_out) dcnt++;
      end
      chk("start_flush_idle", dcnt, 0);

      run("divu_zero2", DIVU, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
      chk("divu_zero2_dz", divzero_out, 1);
      start_in = 1'b1;
      op_in    = MULU;
      opa_in   = 32'hFFFFFFFF;
      opb_in   = 32'd2;
      @(posedge CLK);
      #1;
      start_in = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      chk("mid_busy", busy_out, 1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("mid_rst_busy", busy_out, 0);
      chk("mid_rst_done", done_out, 0);
      chk("mid_rst_hi", hi_out, 0);
      chk("mid_rst_lo", lo_out, 0);
      chk("mid_rst_dz", divzero_out, 0);
      run("post_rst_mulu", MULU, 32'd2, 32'd3, 32'd0, 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
